// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Used by mem_ctrl and mem_ctrl_arb (optional IF port: MEM_CTRL_IF_PORT_EN).
package mem_ctrl_pkg;

   localparam int unsigned RegLen = 32;

   typedef enum logic [1:0] {
      MemIdle  = 2'b00,
      MemRead  = 2'b01,
      MemWrite = 2'b10,
      MemDone  = 2'b11
   } mem_state_t;

   localparam logic [1:0] MemByte = 2'b00;
   localparam logic [1:0] MemHalf = 2'b01;
   localparam logic [1:0] MemWord = 2'b11;

   typedef enum logic {
      ClientData = 1'b0,
      ClientIf   = 1'b1
   } mem_client_t;

   // Size code 2'b10 is the 3-byte access.
   function automatic logic [2:0] byte_count(input logic [1:0] offset);
      case (offset)
         MemByte: return 3'd1;
         MemHalf: return 3'd2;
         MemWord: return 3'd4;
         default: return 3'd3;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Combinational IDLE-state arbitration: MEM beats IF, store beats load.
// IF inputs exist only when MEM_CTRL_IF_PORT_EN is defined.
module mem_ctrl_arb
   import mem_ctrl_pkg::*;
(
   input  logic              ram_read_enable,
   input  logic              ram_write_enable,
   input  logic [RegLen-1:0] ram_addr_o,
   input  logic [RegLen-1:0] ram_data_o,
   input  logic [1:0]        ram_offset,
`ifdef MEM_CTRL_IF_PORT_EN
   input  logic              if_read_enable,
   input  logic [RegLen-1:0] if_addr,
`endif
   output logic              grant,
   output mem_client_t       client,
   output logic              is_write,
   output logic [RegLen-1:0] addr,
   output logic [RegLen-1:0] data,
   output logic [2:0]        count
);

   always_comb begin
      grant    = ram_write_enable | ram_read_enable;
      client   = ClientData;
      is_write = ram_write_enable;
      addr     = ram_addr_o;
      data     = ram_data_o;
      count    = byte_count(ram_offset);
`ifdef MEM_CTRL_IF_PORT_EN
      if (!(ram_write_enable | ram_read_enable) && if_read_enable) begin
         grant    = 1'b1;
         client   = ClientIf;
         is_write = 1'b0;
         addr     = if_addr;
         count    = 3'd4;
      end
`endif
   end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serialises MEM (and optional IF) requests
// onto an 8-bit RAM bus. IF fetch port enabled by MEM_CTRL_IF_PORT_EN.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ram_read_enable,
   input  logic              ram_write_enable,
   input  logic [RegLen-1:0] ram_addr_o,
   input  logic [RegLen-1:0] ram_data_o,
   input  logic [1:0]        ram_offset,
   output logic              ram_done,
   output logic [RegLen-1:0] ram_data,
`ifdef MEM_CTRL_IF_PORT_EN
   input  logic              if_read_enable,
   input  logic [RegLen-1:0] if_addr,
   output logic              if_done,
   output logic [RegLen-1:0] if_data,
`endif
   output logic [RegLen-1:0] mem_a,
   output logic [7:0]        mem_dout,
   input  logic [7:0]        mem_din,
   output logic              mem_wr
);

   mem_state_t        state;
   logic [2:0]        count_q;
   logic [2:0]        issue_q;
   logic [1:0]        cap_q;
   logic              armed;
   logic [RegLen-1:0] addr_q;
   logic [RegLen-1:0] data_q;
   logic [RegLen-1:0] buf_q;
   logic [RegLen-1:0] buf_next;
   logic [RegLen-1:0] next_addr;
   logic              last_cap;

   logic              g_grant;
   mem_client_t       g_client;
   logic              g_write;
   logic [RegLen-1:0] g_addr;
   logic [RegLen-1:0] g_data;
   logic [2:0]        g_count;
`ifdef MEM_CTRL_IF_PORT_EN
   mem_client_t       client_q;
`endif

   mem_ctrl_arb u_arb (
      .ram_read_enable (ram_read_enable),
      .ram_write_enable(ram_write_enable),
      .ram_addr_o      (ram_addr_o),
      .ram_data_o      (ram_data_o),
      .ram_offset      (ram_offset),
`ifdef MEM_CTRL_IF_PORT_EN
      .if_read_enable  (if_read_enable),
      .if_addr         (if_addr),
`endif
      .grant           (g_grant),
      .client          (g_client),
      .is_write        (g_write),
      .addr            (g_addr),
      .data            (g_data),
      .count           (g_count)
   );

   // Read data arrives one cycle after its address, so capture lags issue by one.
   always_comb begin
      buf_next = buf_q;
      buf_next[{cap_q, 3'b000} +: 8] = mem_din;
      next_addr = addr_q + {{(RegLen-3){1'b0}}, issue_q};
      last_cap = armed && ({1'b0, cap_q} == count_q - 3'd1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= MemIdle;
         count_q  <= '0;
         issue_q  <= '0;
         cap_q    <= '0;
         armed    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         buf_q    <= '0;
         mem_a    <= '0;
         mem_dout <= '0;
         mem_wr   <= 1'b0;
         ram_done <= 1'b0;
         ram_data <= '0;
`ifdef MEM_CTRL_IF_PORT_EN
         client_q <= ClientData;
         if_done  <= 1'b0;
         if_data  <= '0;
`endif
      end else begin
         ram_done <= 1'b0;
`ifdef MEM_CTRL_IF_PORT_EN
         if_done  <= 1'b0;
`endif
         unique case (state)
            MemIdle: begin
               if (g_grant) begin
                  addr_q  <= g_addr;
                  data_q  <= g_data;
                  count_q <= g_count;
                  issue_q <= 3'd1;
                  cap_q   <= '0;
                  armed   <= 1'b0;
                  buf_q   <= '0;
                  mem_a   <= g_addr;
`ifdef MEM_CTRL_IF_PORT_EN
                  client_q <= g_client;
`endif
                  if (g_write) begin
                     mem_dout <= g_data[7:0];
                     mem_wr   <= 1'b1;
                     state    <= MemWrite;
                  end else begin
                     mem_wr <= 1'b0;
                     state  <= MemRead;
                  end
               end
            end
            MemRead: begin
`ifdef MEM_CTRL_IF_PORT_EN
               if (client_q == ClientIf && !if_read_enable) state <= MemIdle;
               else
`endif
               begin
                  if (issue_q < count_q) begin
                     mem_a   <= next_addr;
                     issue_q <= issue_q + 3'd1;
                  end
                  armed <= 1'b1;
                  if (armed) begin
                     buf_q <= buf_next;
                     cap_q <= cap_q + 2'd1;
                  end
                  if (last_cap) begin
                     state <= MemDone;
`ifdef MEM_CTRL_IF_PORT_EN
                     if (client_q == ClientIf) begin
                        if_done <= 1'b1;
                        if_data <= buf_next;
                     end else
`endif
                     begin
                        ram_done <= 1'b1;
                        ram_data <= buf_next;
                     end
                  end
               end
            end
            MemWrite: begin
               if (issue_q < count_q) begin
                  mem_a    <= next_addr;
                  mem_dout <= data_q[{issue_q[1:0], 3'b000} +: 8];
                  issue_q  <= issue_q + 3'd1;
               end else begin
                  mem_wr   <= 1'b0;
                  ram_done <= 1'b1;
                  ram_data <= buf_q;
                  state    <= MemDone;
               end
            end
            MemDone: state <= MemIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide RAM model.
// IF-port scenarios are exercised only when MEM_CTRL_IF_PORT_EN is defined.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ram_read_enable = 1'b0;
   logic        ram_write_enable = 1'b0;
   logic [31:0] ram_addr_o = '0;
   logic [31:0] ram_data_o = '0;
   logic [1:0]  ram_offset = '0;
   logic        ram_done;
   logic [31:0] ram_data;
`ifdef MEM_CTRL_IF_PORT_EN
   logic        if_read_enable = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_done;
   logic [31:0] if_data;
`endif
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din = '0;
   logic        mem_wr;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  ram [logic [31:0]];
   logic [31:0] a_log [0:23];
   logic        wr_log [0:23];
   logic [7:0]  d_log [0:23];
   int          done_k;
   logic [31:0] rdata;

   mem_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .ram_read_enable (ram_read_enable),
      .ram_write_enable(ram_write_enable),
      .ram_addr_o      (ram_addr_o),
      .ram_data_o      (ram_data_o),
      .ram_offset      (ram_offset),
      .ram_done        (ram_done),
      .ram_data        (ram_data),
`ifdef MEM_CTRL_IF_PORT_EN
      .if_read_enable  (if_read_enable),
      .if_addr         (if_addr),
      .if_done         (if_done),
      .if_data         (if_data),
`endif
      .mem_a           (mem_a),
      .mem_dout        (mem_dout),
      .mem_din         (mem_din),
      .mem_wr          (mem_wr)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return 8'h00;
   endfunction

   // Synchronous RAM: read byte valid the cycle after its address.
   always @(posedge clk) begin
      mem_din <= ram_rd(mem_a);
      if (mem_wr) ram[mem_a] = mem_dout;
   end

   // Drives one MEM request from c0, logs the bus per cycle, holds until ram_done.
   task automatic run_mem(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] off);
      done_k = -1;
      rdata  = '0;
      for (int k = 0; k < 24; k++) begin
         a_log[k] = '0; wr_log[k] = 1'b0; d_log[k] = '0;
      end
      @(negedge clk);
      ram_read_enable = rd; ram_write_enable = wr;
      ram_addr_o = a; ram_data_o = d; ram_offset = off;
      for (int k = 1; k < 24; k++) begin
         @(negedge clk);
         a_log[k] = mem_a; wr_log[k] = mem_wr; d_log[k] = mem_dout;
         if (ram_done && done_k < 0) begin
            done_k = k; rdata = ram_data;
            ram_read_enable = 1'b0; ram_write_enable = 1'b0;
         end
         if (done_k >= 0 && k >= done_k + 1) break;
      end
      ram_read_enable = 1'b0; ram_write_enable = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      n_cmp++; if (mem_a !== 32'h0) begin n_bad++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
      n_cmp++; if (mem_dout !== 8'h0) begin n_bad++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
      n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
      n_cmp++; if (ram_done !== 1'b0) begin n_bad++; $display("FAIL reset_ram_done: got %b want 0", ram_done); end
      n_cmp++; if (ram_data !== 32'h0) begin n_bad++; $display("FAIL reset_ram_data: got %h want 0", ram_data); end
`ifdef MEM_CTRL_IF_PORT_EN
      n_cmp++; if (if_done !== 1'b0) begin n_bad++; $display("FAIL reset_if_done: got %b want 0", if_done); end
      n_cmp++; if (if_data !== 32'h0) begin n_bad++; $display("FAIL reset_if_data: got %h want 0", if_data); end
`endif
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_lw();
      ram[32'h1000] = 8'h78; ram[32'h1001] = 8'h56; ram[32'h1002] = 8'h34; ram[32'h1003] = 8'h12;
      run_mem(1'b1, 1'b0, 32'h1000, 32'h0, 2'b11);
      for (int k = 1; k <= 4; k++) begin
         n_cmp++;
         if (a_log[k] !== 32'(32'h1000 + k - 1) || wr_log[k] !== 1'b0) begin
            n_bad++; $display("FAIL lw_addr_c%0d: got %h wr=%b want %h wr=0", k, a_log[k], wr_log[k], 32'(32'h1000 + k - 1));
         end
      end
      n_cmp++; if (done_k !== 6) begin n_bad++; $display("FAIL lw_done_cycle: got %0d want 6", done_k); end
      n_cmp++; if (rdata !== 32'h12345678) begin n_bad++; $display("FAIL lw_data: got %h want 12345678", rdata); end
   endtask

   task automatic test_narrow_reads();
      run_mem(1'b1, 1'b0, 32'h1002, 32'h0, 2'b00);
      n_cmp++; if (done_k !== 3) begin n_bad++; $display("FAIL lb_done_cycle: got %0d want 3", done_k); end
      n_cmp++; if (rdata !== 32'h00000034) begin n_bad++; $display("FAIL lb_data: got %h want 00000034", rdata); end
      run_mem(1'b1, 1'b0, 32'h1000, 32'h0, 2'b10);
      n_cmp++; if (done_k !== 5) begin n_bad++; $display("FAIL l3_done_cycle: got %0d want 5", done_k); end
      n_cmp++; if (rdata !== 32'h00345678) begin n_bad++; $display("FAIL l3_data: got %h want 00345678", rdata); end
   endtask

   task automatic test_sb();
      int nwr;
      run_mem(1'b0, 1'b1, 32'h20, 32'h000000AB, 2'b00);
      nwr = 0;
      for (int k = 1; k < 24; k++) if (wr_log[k] === 1'b1) nwr++;
      n_cmp++; if (nwr !== 1) begin n_bad++; $display("FAIL sb_write_count: got %0d want 1", nwr); end
      n_cmp++;
      if (wr_log[1] !== 1'b1 || a_log[1] !== 32'h20 || d_log[1] !== 8'hAB) begin
         n_bad++; $display("FAIL sb_c1: got wr=%b a=%h d=%h want wr=1 a=00000020 d=ab", wr_log[1], a_log[1], d_log[1]);
      end
      n_cmp++; if (done_k !== 2) begin n_bad++; $display("FAIL sb_done_cycle: got %0d want 2", done_k); end
      n_cmp++; if (ram_rd(32'h20) !== 8'hAB) begin n_bad++; $display("FAIL sb_ram: got %h want ab", ram_rd(32'h20)); end
   endtask

   task automatic test_sh_wrap();
      run_mem(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0000BEEF, 2'b01);
      n_cmp++;
      if (wr_log[1] !== 1'b1 || a_log[1] !== 32'hFFFFFFFF || d_log[1] !== 8'hEF) begin
         n_bad++; $display("FAIL sh_c1: got wr=%b a=%h d=%h want wr=1 a=ffffffff d=ef", wr_log[1], a_log[1], d_log[1]);
      end
      n_cmp++;
      if (wr_log[2] !== 1'b1 || a_log[2] !== 32'h0 || d_log[2] !== 8'hBE) begin
         n_bad++; $display("FAIL sh_c2: got wr=%b a=%h d=%h want wr=1 a=00000000 d=be", wr_log[2], a_log[2], d_log[2]);
      end
      n_cmp++; if (wr_log[3] !== 1'b0) begin n_bad++; $display("FAIL sh_c3_wr: got %b want 0", wr_log[3]); end
      n_cmp++; if (done_k !== 3) begin n_bad++; $display("FAIL sh_done_cycle: got %0d want 3", done_k); end
      n_cmp++; if (ram_rd(32'h0) !== 8'hBE) begin n_bad++; $display("FAIL sh_ram0: got %h want be", ram_rd(32'h0)); end
   endtask

   task automatic test_sw_readback();
      run_mem(1'b0, 1'b1, 32'h200, 32'hCAFEF00D, 2'b11);
      n_cmp++; if (done_k !== 5) begin n_bad++; $display("FAIL sw_done_cycle: got %0d want 5", done_k); end
      run_mem(1'b1, 1'b0, 32'h200, 32'h0, 2'b11);
      n_cmp++; if (rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL sw_readback: got %h want cafef00d", rdata); end
   endtask

   task automatic test_write_wins();
      run_mem(1'b1, 1'b1, 32'h40, 32'h0000005A, 2'b00);
      n_cmp++; if (wr_log[1] !== 1'b1) begin n_bad++; $display("FAIL ww_wr: got %b want 1", wr_log[1]); end
      n_cmp++; if (done_k !== 2) begin n_bad++; $display("FAIL ww_done_cycle: got %0d want 2", done_k); end
      n_cmp++; if (ram_rd(32'h40) !== 8'h5A) begin n_bad++; $display("FAIL ww_ram: got %h want 5a", ram_rd(32'h40)); end
   endtask

`ifdef MEM_CTRL_IF_PORT_EN
   task automatic test_if_arb();
      int rk, ik;
      logic [31:0] idata;
      ram[32'h2000] = 8'h0D; ram[32'h2001] = 8'hF0; ram[32'h2002] = 8'hAD; ram[32'h2003] = 8'hDE;
      rk = -1; ik = -1; idata = '0;
      @(negedge clk);
      ram_read_enable = 1'b1; ram_write_enable = 1'b0; ram_addr_o = 32'h1000; ram_offset = 2'b11;
      if_read_enable = 1'b1; if_addr = 32'h2000;
      for (int k = 1; k < 24; k++) begin
         @(negedge clk);
         if (ram_done && rk < 0) begin rk = k; rdata = ram_data; ram_read_enable = 1'b0; end
         if (if_done && ik < 0) begin ik = k; idata = if_data; if_read_enable = 1'b0; end
         if (ik >= 0) break;
      end
      ram_read_enable = 1'b0; if_read_enable = 1'b0;
      n_cmp++; if (rk !== 6) begin n_bad++; $display("FAIL arb_mem_done: got %0d want 6", rk); end
      n_cmp++; if (rdata !== 32'h12345678) begin n_bad++; $display("FAIL arb_mem_data: got %h want 12345678", rdata); end
      n_cmp++; if (ik !== 13) begin n_bad++; $display("FAIL arb_if_done: got %0d want 13", ik); end
      n_cmp++; if (idata !== 32'hDEADF00D) begin n_bad++; $display("FAIL arb_if_data: got %h want deadf00d", idata); end
   endtask

   task automatic test_if_abort();
      int seen;
      @(negedge clk);
      if_read_enable = 1'b1; if_addr = 32'h2000;
      @(negedge clk);
      @(negedge clk);
      if_read_enable = 1'b0;
      seen = 0;
      repeat (8) begin @(negedge clk); if (if_done) seen++; end
      n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_if_done: got %0d pulses want 0", seen); end
      run_mem(1'b1, 1'b0, 32'h2001, 32'h0, 2'b00);
      n_cmp++; if (done_k !== 3) begin n_bad++; $display("FAIL abort_lb_done: got %0d want 3", done_k); end
      n_cmp++; if (rdata !== 32'h000000F0) begin n_bad++; $display("FAIL abort_lb_data: got %h want 000000f0", rdata); end
   endtask
`endif

   task automatic test_reset_mid_sw();
      int seen;
      for (int i = 0; i < 4; i++) ram[32'(32'h300 + i)] = 8'h00;
      @(negedge clk);
      ram_write_enable = 1'b1; ram_addr_o = 32'h300; ram_data_o = 32'h11223344; ram_offset = 2'b11;
      @(negedge clk);
      n_cmp++; if (mem_wr !== 1'b1) begin n_bad++; $display("FAIL rst_sw_c1_wr: got %b want 1", mem_wr); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_sw_wr: got %b want 0", mem_wr); end
      n_cmp++;
      if (mem_a !== 32'h0 || mem_dout !== 8'h0 || ram_done !== 1'b0) begin
         n_bad++; $display("FAIL rst_sw_outs: got a=%h d=%h done=%b want zeros", mem_a, mem_dout, ram_done);
      end
      ram_write_enable = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      n_cmp++; if (ram_rd(32'h300) !== 8'h44) begin n_bad++; $display("FAIL rst_sw_byte0: got %h want 44", ram_rd(32'h300)); end
      n_cmp++; if (ram_rd(32'h301) !== 8'h00) begin n_bad++; $display("FAIL rst_sw_byte1: got %h want 00", ram_rd(32'h301)); end
      seen = 0;
      repeat (8) begin @(negedge clk); if (ram_done) seen++; end
      n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_sw_done: got %0d pulses want 0", seen); end
      run_mem(1'b1, 1'b0, 32'h1000, 32'h0, 2'b00);
      n_cmp++; if (rdata !== 32'h00000078 || done_k !== 3) begin
         n_bad++; $display("FAIL rst_sw_after_lb: got %h at c%0d want 00000078 at c3", rdata, done_k);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_narrow_reads();
      test_sb();
      test_sh_wrap();
      test_sw_readback();
      test_write_wins();
`ifdef MEM_CTRL_IF_PORT_EN
      test_if_arb();
      test_if_abort();
`endif
      test_reset_mid_sw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
